// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone B4 pipelined master behind the 34-bit command/response port
module wb_cmd_master #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_stb,
  input  logic [33:0]   cmd_word,
  output logic          cmd_busy,
  output logic          rsp_stb,
  output logic [33:0]   rsp_word,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam logic [1:0] RSP_WACK = 2'b00;
  localparam logic [1:0] RSP_RDAT = 2'b01;
  localparam logic [1:0] RSP_ERR  = 2'b10;
  localparam logic [1:0] RSP_SET  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;

  state_t        state, state_d;
  logic [AW-1:0] addr;
  logic          inc;
  logic [CW-1:0] tmo_cnt;
  logic [1:0]    op;
  logic [31:0]   err_addr;
  logic          accept, sampled, bus_ok, bus_fail, timed_out;

  assign op       = cmd_word[33:32];
  assign err_addr = 32'({addr, 2'b00});

  assign o_wb_cyc  = (state == S_STROBE) || (state == S_WAIT);
  assign o_wb_stb  = (state == S_STROBE);
  assign o_wb_addr = addr;
  assign o_wb_sel  = 4'hF;
  assign cmd_busy  = (state != S_IDLE);
  assign rsp_stb   = (state == S_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    sampled   = 1'b0;
    bus_ok    = 1'b0;
    bus_fail  = 1'b0;
    timed_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_stb && op != OP_NOP) begin
          accept  = 1'b1;
          state_d = (op == OP_SET) ? S_RESP : S_STROBE;
        end
      end
      S_STROBE, S_WAIT: begin
        // ack/err only count once the strobe has been (or is being) accepted
        sampled = (state == S_WAIT) || !i_wb_stall;
        if (state == S_STROBE && !i_wb_stall) state_d = S_WAIT;
        if (sampled && i_wb_err) begin
          bus_fail = 1'b1;
          state_d  = S_RESP;
        end else if (sampled && i_wb_ack) begin
          bus_ok  = 1'b1;
          state_d = S_RESP;
        end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
          timed_out = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      inc       <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_data <= '0;
      rsp_word  <= '0;
      tmo_cnt   <= '0;
    end else begin
      if (accept) begin
        if (op == OP_SET) begin
          addr     <= cmd_word[AW+1:2];
          inc      <= cmd_word[0];
          rsp_word <= {RSP_SET, cmd_word[31:0]};
        end else begin
          o_wb_we   <= (op == OP_WRITE);
          o_wb_data <= cmd_word[31:0];
          tmo_cnt   <= '0;
        end
      end
      if (o_wb_cyc) tmo_cnt <= tmo_cnt + CW'(1);
      if (bus_ok) begin
        rsp_word <= o_wb_we ? {RSP_WACK, 32'h0} : {RSP_RDAT, i_wb_data};
        if (inc) addr <= addr + AW'(1);
      end
      if (bus_fail || timed_out) rsp_word <= {RSP_ERR, err_addr};
    end
  end

endmodule
